mul_pipe: RTL

- Parametrised pipelined integer multiplier for the EX/MEM datapath. Replaces the fixed two-stage partial-product split.
- Supports the LoongArch mul.w, mulh.w and mulh.wu result selections.
- Depth is configurable, with a valid/tag pipeline and stall/flush control driven by the hazard and branch logic.
- Outputs a destination-register tag with each result so forwarding and writeback can match it.

---
 rtl/mul_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mul_pipe.sv
// Pipelined WIDTH x WIDTH multiplier with valid/tag pipeline, stall and flush.
// Optional MUL_PEND_TAG_EN exposes per-stage valid bits and tags.
module mul_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        src0,
   input  logic [WIDTH-1:0]        src1,
   input  logic [1:0]              op,
   input  logic [TAG_W-1:0]        in_tag,
   input  logic                    stall,
   input  logic                    flush,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_res,
   output logic [TAG_W-1:0]        out_tag,
`ifdef MUL_PEND_TAG_EN
   output logic [STAGES-1:0]       pend_vld,
   output logic [STAGES*TAG_W-1:0] pend_tag,
`endif
   output logic                    busy
);

   localparam int PW = 2*WIDTH + 2;
   localparam int H  = (WIDTH + 1) / 2;

   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("mul_pipe: STAGES must be within 1..4");
   end

   logic                    ext_sgn;
   logic                    sel_hi;
   logic signed [PW-1:0]    a_w;
   logic signed [PW-1:0]    b_w;
   logic [STAGES-1:0]       vld;
   logic [TAG_W-1:0]        tag_q [STAGES];

   always_comb begin
      ext_sgn = 1'b0;
      sel_hi  = 1'b0;
      unique case (1'b1)
         (op == 2'b01): begin
            ext_sgn = 1'b1;
            sel_hi  = 1'b1;
         end
         (op == 2'b10): sel_hi = 1'b1;
         default: ;
      endcase
   end

   // Sign/zero extension straight to product width keeps the multiply exact.
   assign a_w = {{(PW-WIDTH){ext_sgn & src0[WIDTH-1]}}, src0};
   assign b_w = {{(PW-WIDTH){ext_sgn & src1[WIDTH-1]}}, src1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= '0;
         for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
      end else if (flush) begin
         vld <= '0;
      end else if (!stall) begin
         vld[0]   <= in_valid;
         tag_q[0] <= in_tag;
         for (int i = 1; i < STAGES; i++) begin
            vld[i]   <= vld[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   if (STAGES == 1) begin : g_one
      logic signed [PW-1:0] prod0;
      logic [WIDTH-1:0]     res_q;
      logic                 unused_hi;

      assign prod0     = a_w * b_w;
      assign unused_hi = ^prod0[PW-1:2*WIDTH];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            res_q <= '0;
         end else if (!stall) begin
            res_q <= sel_hi ? prod0[2*WIDTH-1:WIDTH]
                            : prod0[WIDTH-1:0];
         end
      end

      assign out_res = res_q;
   end else begin : g_multi
      logic signed [PW-1:0] pp_lo_d;
      logic signed [PW-1:0] pp_hi_d;
      logic signed [PW-1:0] pp_lo_q;
      logic signed [PW-1:0] pp_hi_q;
      logic                 hi0;
      logic signed [PW-1:0] prod1;
      logic [WIDTH-1:0]     res_d1;
      logic [WIDTH-1:0]     res_q [1:STAGES-1];
      logic                 unused_hi;

      // b = b_lo + (b >>> H) * 2^H, so the two partials sum back exactly.
      assign pp_lo_d = a_w * $signed({{(PW-H){1'b0}}, b_w[H-1:0]});
      assign pp_hi_d = a_w * (b_w >>> H);

      assign prod1     = pp_lo_q + (pp_hi_q <<< H);
      assign res_d1    = hi0 ? prod1[2*WIDTH-1:WIDTH]
                             : prod1[WIDTH-1:0];
      assign unused_hi = ^prod1[PW-1:2*WIDTH];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            hi0     <= 1'b0;
            pp_lo_q <= '0;
            pp_hi_q <= '0;
            for (int i = 1; i < STAGES; i++) res_q[i] <= '0;
         end else if (!stall) begin
            hi0      <= sel_hi;
            pp_lo_q  <= pp_lo_d;
            pp_hi_q  <= pp_hi_d;
            res_q[1] <= res_d1;
            for (int i = 2; i < STAGES; i++) res_q[i] <= res_q[i-1];
         end
      end

      assign out_res = res_q[STAGES-1];
   end

   assign in_ready  = !stall;
   assign out_valid = vld[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];
   assign busy      = |vld;

`ifdef MUL_PEND_TAG_EN
   always_comb begin
      pend_vld = vld;
      pend_tag = '0;
      for (int i = 0; i < STAGES; i++)
         pend_tag[i*TAG_W +: TAG_W] = tag_q[i];
   end
`endif

endmodule
